// File: rtl/csr_file.sv
// Machine-mode CSR file: CSRRW/S/C(+I), trap entry, mret, optional counters.
// Ports: clk, rst (sync high); is_csr, csr_read_en, csr_write_en, funct3,
//   csr_addr, rs1_idx, rs1_data (CSR op); instr_retire; trap_valid,
//   trap_cause, trap_pc; mret; outputs csr_rdata, illegal_csr (comb),
//   mtvec_out, mepc_out, mie_out.
// Define CSR_COUNTERS_EN to build the 64-bit mcycle/minstret counters.
module csr_file #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
  parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        is_csr,
  input  logic        csr_read_en,
  input  logic        csr_write_en,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr,
  input  logic [4:0]  rs1_idx,
  input  logic [31:0] rs1_data,
  input  logic        instr_retire,
  input  logic        trap_valid,
  input  logic [31:0] trap_cause,
  input  logic [31:0] trap_pc,
  input  logic        mret,
  output logic [31:0] csr_rdata,
  output logic        illegal_csr,
  output logic [31:0] mtvec_out,
  output logic [31:0] mepc_out,
  output logic        mie_out
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MISA     = 12'h301;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MHARTID  = 12'hF14;
  localparam logic [31:0] MISA_VAL   = 32'h4000_1100;

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

`ifdef CSR_COUNTERS_EN
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;

  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
`else
  logic unused_retire;
  assign unused_retire = instr_retire;
`endif

  logic        addr_impl;
  logic [31:0] old_val;
  logic [31:0] mstatus_val;
  logic [31:0] src;
  logic [31:0] wdata;
  logic        op_valid;
  logic        suppressed;
  logic        read_only;
  logic        we;

  // MPP is hardwired to M-mode (2'b11).
  assign mstatus_val = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

  always_comb begin
    addr_impl = 1'b1;
    old_val   = 32'h0;
    case (csr_addr)
      A_MSTATUS:   old_val = mstatus_val;
      A_MISA:      old_val = MISA_VAL;
      A_MTVEC:     old_val = mtvec_q;
      A_MSCRATCH:  old_val = mscratch_q;
      A_MEPC:      old_val = mepc_q;
      A_MCAUSE:    old_val = mcause_q;
      A_MHARTID:   old_val = HART_ID;
`ifdef CSR_COUNTERS_EN
      A_MCYCLE,
      A_CYCLE:     old_val = mcycle_q[31:0];
      A_MCYCLEH,
      A_CYCLEH:    old_val = mcycle_q[63:32];
      A_MINSTRET,
      A_INSTRET:   old_val = minstret_q[31:0];
      A_MINSTRETH,
      A_INSTRETH:  old_val = minstret_q[63:32];
`endif
      default:     addr_impl = 1'b0;
    endcase
  end

  assign src = funct3[2] ? {27'b0, rs1_idx} : rs1_data;

  always_comb begin
    wdata = old_val;
    case (funct3[1:0])
      2'b01:   wdata = src;
      2'b10:   wdata = old_val | src;
      2'b11:   wdata = old_val & ~src;
      default: wdata = old_val;
    endcase
  end

  // funct3 x00 is not a CSR op (ecall/mret etc.), so it never faults.
  assign op_valid   = funct3[1:0] != 2'b00;
  assign suppressed = funct3[1] & (rs1_idx == 5'd0);
  assign read_only  = csr_addr[11:10] == 2'b11;

  assign illegal_csr = is_csr & op_valid &
                       (~addr_impl | (read_only & ~suppressed));

  assign we = is_csr & csr_write_en & op_valid & ~suppressed &
              ~illegal_csr & ~trap_valid;

  assign csr_rdata = (is_csr & csr_read_en & addr_impl) ? old_val : 32'h0;

  always_comb begin
    mie_d      = mie_q;
    mpie_d     = mpie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;

    if (we) begin
      case (csr_addr)
        A_MSTATUS: begin
          mie_d  = wdata[3];
          mpie_d = wdata[7];
        end
        A_MTVEC:    mtvec_d    = {wdata[31:2], 2'b00};
        A_MSCRATCH: mscratch_d = wdata;
        A_MEPC:     mepc_d     = {wdata[31:2], 2'b00};
        A_MCAUSE:   mcause_d   = wdata;
        default:    ;
      endcase
    end

    // we is already low on a trap; mret overrides an mstatus write.
    if (trap_valid) begin
      mepc_d   = {trap_pc[31:2], 2'b00};
      mcause_d = trap_cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (mret) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end
  end

`ifdef CSR_COUNTERS_EN
  // A write to one half replaces that half and freezes the other,
  // so no increment or carry is applied in that cycle.
  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'b0, instr_retire & ~trap_valid};
    if (we) begin
      case (csr_addr)
        A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wdata};
        A_MCYCLEH:   mcycle_d   = {wdata, mcycle_q[31:0]};
        A_MINSTRET:  minstret_d = {minstret_q[63:32], wdata};
        A_MINSTRETH: minstret_d = {wdata, minstret_q[31:0]};
        default:     ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcycle_q   <= 64'h0;
      minstret_q <= 64'h0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtvec_q    <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q <= 32'h0;
      mepc_q     <= 32'h0;
      mcause_q   <= 32'h0;
    end else begin
      mie_q      <= mie_d;
      mpie_q     <= mpie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

  assign mtvec_out = mtvec_q;
  assign mepc_out  = mepc_q;
  assign mie_out   = mie_q;

endmodule
